// File: rtl/memprog_arb.sv
// Read-port arbiter for the 1024x16 program memory: CPU fetch has fixed
// priority over debug read-back, with a saturating wait counter bounding debug starvation.
module memprog_arb #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_valid,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_data,
  output logic          dbg_valid,
  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_MAX  = 4'hF;
  localparam logic [3:0] STARVE_AT = 4'(MAXWAIT);

  owner_t        owner;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_cnt_nxt;
  logic [AW-1:0] last_a;
  logic          starve;

  assign starve = (wait_cnt >= STARVE_AT);

  // Debug only overtakes a requesting CPU once it has waited MAXWAIT cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    owner = OWN_NONE;
    if (dbg_req && (starve || !cpu_req)) begin
      owner = OWN_DBG;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end
  end

  assign cpu_gnt = (owner == OWN_CPU);
  assign dbg_gnt = (owner == OWN_DBG);

  always_comb begin
    mem_a = last_a;
    unique case (owner)
      OWN_CPU:  mem_a = cpu_addr;
      OWN_DBG:  mem_a = dbg_addr;
      default:  mem_a = last_a;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = '0;
    if (dbg_req && !dbg_gnt) begin
      wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 4'd1;
    end
  end

  // Idle cycles keep the last granted address on the memory pins.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wait_cnt <= '0;
      last_a   <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (owner != OWN_NONE) begin
        last_a <= mem_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_data  <= '0;
      cpu_valid <= 1'b0;
    end else begin
      cpu_valid <= cpu_gnt;
      if (cpu_gnt) begin
        cpu_data <= mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_data <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_memprog_arb.sv
// Self-checking bench for memprog_arb: reference arbitration model plus
// per-requester scoreboard queues of expected read data.
module tb_memprog_arb;

  localparam int AW      = 10;
  localparam int DW      = 16;
  localparam int MAXWAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, dbg_req;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic          cpu_gnt, dbg_gnt, cpu_valid, dbg_valid;
  logic [DW-1:0] cpu_data, dbg_data, mem_rd;
  logic [AW-1:0] mem_a;

  logic [DW-1:0] mem [1024];
  assign mem_rd = mem[mem_a];

  always #5 clk = ~clk;

  memprog_arb #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_data(cpu_data), .cpu_valid(cpu_valid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_data(dbg_data), .dbg_valid(dbg_valid),
    .mem_a(mem_a), .mem_rd(mem_rd)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dbg_q[$];

  int            m_wait;
  logic [AW-1:0] m_last;
  logic [DW-1:0] m_cpu_data, m_dbg_data;

  logic          e_cg, e_dg;
  logic          s_cpu_gnt, s_dbg_gnt, s_cpu_valid, s_dbg_valid;
  logic [DW-1:0] s_dbg_data, s_cpu_data;
  logic [AW-1:0] s_mem_a;
  int            s_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cpu_q.delete();
    dbg_q.delete();
    m_wait     = 0;
    m_last     = '0;
    m_cpu_data = '0;
    m_dbg_data = '0;
  endtask

  // One clock cycle: inputs already driven; checks mid-cycle at the negedge.
  task automatic tick();
    logic          starve;
    logic [AW-1:0] e_a;
    logic [DW-1:0] exp;
    @(negedge clk);
    starve = (m_wait >= MAXWAIT);
    e_cg   = cpu_req && !(starve && dbg_req);
    e_dg   = dbg_req && !e_cg;
    e_a    = e_cg ? cpu_addr : (e_dg ? dbg_addr : m_last);
    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
    check("mem_a", 32'(mem_a), 32'(e_a));
    check("wait_cnt", 32'(dut.wait_cnt), 32'(m_wait));
    if (cpu_q.size() > 0) begin
      exp = cpu_q.pop_front();
      check("cpu_valid", 32'(cpu_valid), 32'd1);
      m_cpu_data = exp;
    end else begin
      check("cpu_valid", 32'(cpu_valid), 32'd0);
    end
    check("cpu_data", 32'(cpu_data), 32'(m_cpu_data));
    if (dbg_q.size() > 0) begin
      exp = dbg_q.pop_front();
      check("dbg_valid", 32'(dbg_valid), 32'd1);
      m_dbg_data = exp;
    end else begin
      check("dbg_valid", 32'(dbg_valid), 32'd0);
    end
    check("dbg_data", 32'(dbg_data), 32'(m_dbg_data));
    s_cpu_gnt = cpu_gnt;  s_dbg_gnt = dbg_gnt;
    s_cpu_valid = cpu_valid; s_dbg_valid = dbg_valid;
    s_cpu_data = cpu_data; s_dbg_data = dbg_data;
    s_mem_a = mem_a; s_wait = int'(dut.wait_cnt);
    if (e_cg) cpu_q.push_back(mem[cpu_addr]);
    if (e_dg) dbg_q.push_back(mem[dbg_addr]);
    if (dbg_req && !e_dg) m_wait = (m_wait == 15) ? 15 : m_wait + 1;
    else                  m_wait = 0;
    if (e_cg || e_dg) m_last = e_a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_wait [6];
    exp_wait = '{0, 1, 2, 3, 4, 0};
    for (int k = 0; k < 1024; k++) mem[k] = 16'(k) + 16'h1000;
    mem[10'h3FF] = 16'hBEEF;

    reset = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_addr = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    reset = 1'b1;

    // CPU streaming 0..3
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_addr = 10'(i);
      tick();
      check("stream_gnt", 32'(s_cpu_gnt), 32'd1);
      if (i > 0) begin
        check("stream_valid", 32'(s_cpu_valid), 32'd1);
        check("stream_data", 32'(s_cpu_data), 32'h1000 + 32'(i - 1));
      end
    end
    cpu_req = 1'b0;
    tick();
    check("stream_last", 32'(s_cpu_data), 32'h1003);

    // Debug alone at the top address
    dbg_req = 1'b1; dbg_addr = 10'h3FF;
    tick();
    check("dbg_alone_gnt", 32'(s_dbg_gnt), 32'd1);
    dbg_req = 1'b0;
    tick();
    check("dbg_alone_valid", 32'(s_dbg_valid), 32'd1);
    check("dbg_alone_data", 32'(s_dbg_data), 32'hBEEF);
    tick();
    check("dbg_alone_pulse", 32'(s_dbg_valid), 32'd0);

    // Starvation bound: debug wins in its fifth requesting cycle
    cpu_req = 1'b1; cpu_addr = 10'd2; dbg_req = 1'b1; dbg_addr = 10'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("starve_dbg_gnt", 32'(s_dbg_gnt), 32'(i == 4));
      check("starve_cpu_gnt", 32'(s_cpu_gnt), 32'(i != 4));
      check("starve_wait", 32'(s_wait), 32'(exp_wait[i]));
      if (s_dbg_gnt) dbg_req = 1'b0;
    end
    tick();
    check("starve_dbg_data", 32'(s_dbg_data), 32'h1005);

    // Idle address hold after CPU addr 7
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_addr = 10'd7;
    tick();
    cpu_req = 1'b0; cpu_addr = 10'd100;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("idle_mem_a", 32'(s_mem_a), 32'd7);
      tick();
      check("idle_no_valid", 32'(s_cpu_valid | s_dbg_valid), 32'd0);
    end

    // Debug withdrawal clears the counter; a new request waits in full again
    cpu_req = 1'b1; cpu_addr = 10'd1; dbg_req = 1'b1; dbg_addr = 10'd9;
    repeat (2) tick();
    dbg_req = 1'b0;
    tick();
    check("withdraw_wait", 32'(s_wait), 32'd2);
    tick();
    check("withdraw_clear", 32'(s_wait), 32'd0);
    dbg_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rewait_dbg_gnt", 32'(s_dbg_gnt), 32'(i == 4));
      if (s_dbg_gnt) dbg_req = 1'b0;
    end

    // Random traffic; requests held until granted
    cpu_req = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!cpu_req || s_cpu_gnt) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_addr = 10'($urandom);
      end
      if (!dbg_req || s_dbg_gnt) begin
        dbg_req = 1'($urandom_range(0, 1)); dbg_addr = 10'($urandom);
      end
      tick();
    end

    // Asynchronous reset mid-cycle with CPU requesting and a valid pulse live
    cpu_req = 1'b1; cpu_addr = 10'd9; dbg_req = 1'b1; dbg_addr = 10'd3;
    tick();
    #2 reset = 1'b0;
    #1;
    check("arst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("arst_cpu_data", 32'(cpu_data), 32'd0);
    check("arst_dbg_valid", 32'(dbg_valid), 32'd0);
    check("arst_dbg_data", 32'(dbg_data), 32'd0);
    check("arst_wait", 32'(dut.wait_cnt), 32'd0);
    check("arst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("arst_mem_a", 32'(mem_a), 32'd9);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_valid", 32'(cpu_valid), 32'd0);
    reset = 1'b1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    check("post_rst_valid", 32'(s_cpu_valid), 32'd0);
    check("post_rst_mem_a", 32'(s_mem_a), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memprog_arb.md
# memprog_arb

Read-port arbiter for the 1024×16 program memory. It shares the memory's single combinational read port between the CPU instruction fetch and a debug/monitor read-back requester. The CPU has fixed priority, and a wait counter bounds debug starvation. Each requester gets a registered data word and a one-cycle valid pulse. The block sits between the fetch stage/debug unit and the program memory's `a`/`rd` pins.

## Interface
Parameters:
- `AW`, 10, address width (1024 words)
- `DW`, 16, data width
- `MAXWAIT`, 4, number of consecutive denied debug cycles after which debug wins (1..15)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (`reset`=0 resets immediately).
- `cpu_req`  in  1  CPU read request; held until granted.
- `cpu_addr`  in  AW  CPU word address; stable while `cpu_req`=1.
- `cpu_gnt`  out  1  combinational; CPU owns the port this cycle.
- `cpu_data`  out  DW  registered read data for CPU.
- `cpu_valid`  out  1  one-cycle pulse; `cpu_data` is new.
- `dbg_req`  in  1  debug read request; held until granted.
- `dbg_addr`  in  AW  debug word address.
- `dbg_gnt`  out  1  combinational; debug owns the port this cycle.
- `dbg_data`  out  DW  registered read data for debug.
- `dbg_valid`  out  1  one-cycle pulse; `dbg_data` is new.
- `mem_a`  out  AW  address to program memory `a`.
- `mem_rd`  in  DW  combinational data from program memory `rd`.

## Operation
- Exactly one or zero grants per cycle; `cpu_gnt` and `dbg_gnt` are never both 1.
- Priority:
  - Default: CPU over debug.
  - If `starve`=1, debug over CPU.
- `starve` = (`wait_cnt` ≥ `MAXWAIT`), from a 4-bit register.
- `wait_cnt` behaviour:
  - Increments (saturating at 15) each cycle with `dbg_req`=1 and `dbg_gnt`=0.
  - Clears to 0 on any cycle with `dbg_gnt`=1 or `dbg_req`=0.
- `mem_a` selection (combinational):
  - Granted requester's address.
  - With no grant, `last_a`: a register holding the address of the most recent grant, 0 after reset. This keeps the memory address stable in idle cycles.
- On a grant cycle the rising edge captures `mem_rd` into the winner's `*_data` register and sets that `*_valid` to 1 for the following cycle only.
- A losing requester keeps `req` and `addr` held; it is evaluated again next cycle with no penalty other than the counter.
- Back-to-back requests from the same requester may be granted every cycle, giving full throughput.
- `*_data` holds its last captured value until the next grant for that requester. Each requester's data register is independent of the other's.
- Request dropped before grant: allowed, with no side effect except clearing `wait_cnt` for debug.

## Timing
- Grant latency: 0 cycles. `*_gnt` follows `*_req` combinationally in the same cycle, subject to priority.
- Data latency: 1 cycle. Address presented in cycle N gives `*_data` valid with `*_valid`=1 in cycle N+1.
- Starvation bound: with `cpu_req` held at 1 continuously, a debug request is granted in its (`MAXWAIT`+1)-th cycle of asserting. After that grant the CPU regains priority on the next cycle.
- Reset (`reset`=0, asynchronous, any time including mid-transfer):
  - `cpu_data`=0, `dbg_data`=0, `cpu_valid`=0, `dbg_valid`=0, `wait_cnt`=0, `last_a`=0.
  - Grants still follow requests combinationally, but no capture occurs while reset is 0.
  - An in-flight capture is discarded; no valid pulse follows release.
- Reset release: the first edge with `reset`=1 behaves as an ordinary cycle.
- Simultaneous `cpu_req` and `dbg_req` with `starve`=0: CPU is granted and `wait_cnt` increments.

## Test plan
- Reset check: assert `reset`=0 mid-cycle with `cpu_req`=1 → all outputs are 0 asynchronously and `mem_a`=`cpu_addr`. After release there is no stale `cpu_valid`.
- CPU streaming: memory preloaded with `mem[k]`=k+16'h1000. CPU requests addresses 0,1,2,3 in consecutive cycles → `cpu_gnt`=1 every cycle and `cpu_data`=1000,1001,1002,1003 on consecutive cycles, each with `cpu_valid`=1.
- Debug alone: `dbg_req`=1, `dbg_addr`=10'h3FF, `mem[3FF]`=16'hBEEF → `dbg_gnt`=1 in the same cycle; next cycle `dbg_data`=BEEF and `dbg_valid`=1 for exactly one cycle.
- Starvation, `MAXWAIT`=4: CPU requests continuously while debug requests addr 5 from cycle 0 → CPU granted in cycles 0–3, debug granted in cycle 4, CPU granted again in cycle 5. `wait_cnt` reads 0,1,2,3,4 then 0.
- Idle address hold: grant CPU addr 7, then deassert all requests for 3 cycles → `mem_a` stays 7 and no valid pulses occur.
- Debug withdrawal: debug requests for 2 cycles while denied, then drops → `wait_cnt` returns to 0. A new debug request then waits the full `MAXWAIT` cycles again.
